spi_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `spi_master` (8-bit, `start`/`busy` handshake) between up to `N_REQ` requesters. It accepts byte-transfer requests, latches the winner's data, and drives `spi_start`/`spi_data` to the master. It tracks the master's `busy` to report per-requester completion. It sits between client logic and `spi_master`; `sclk`/`mosi`/`cs` pass straight from the master to the pins and do not go through this block.

---
 rtl/spi_req_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8-bit spi_master between N_REQ requesters.
// Optional watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]          o_ack,
    output logic [N_REQ-1:0]          o_done,
    output logic [$clog2(N_REQ)-1:0]  o_grant_id,
    output logic                      o_arb_busy,
    output logic                      o_spi_start,
    output logic [DATA_W-1:0]         o_spi_data,
    input  logic                      i_spi_busy,
    output logic                      o_timeout_err
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned SUM_W = ID_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitHi,
        StWaitLo
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ID_W-1:0]     r_last_grant;
    logic [ID_W-1:0]     r_grant_id;
    logic [DATA_W-1:0]   r_spi_data;
    logic [N_REQ-1:0]    r_ack;
    logic [N_REQ-1:0]    r_done;
    logic                r_arb_busy;
    logic                r_spi_start;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    logic [SUM_W-1:0]    w_sum;
    logic [DATA_W-1:0]   w_win_data;
    logic                w_grant;
    logic                w_finish;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]    r_to_cnt;
    logic                r_timeout_err;
    logic                w_waiting;
    logic                w_to_hit;
    logic                w_timeout;

    assign w_waiting = (r_state == StWaitHi) || (r_state == StWaitLo);
    assign w_to_hit  = w_waiting && (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last_grant;
        w_sum    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, r_last_grant} + SUM_W'(k);
            if (w_sum >= SUM_W'(N_REQ)) begin
                w_sum = w_sum - SUM_W'(N_REQ);
            end
            if (!w_found && i_req[w_sum[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_win_data = i_req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            StIdle: begin
                if (w_found && !i_spi_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = StStart;
                end
            end
            StStart: begin
                w_state_nxt = StWaitHi;
            end
            StWaitHi: begin
                if (i_spi_busy) begin
                    w_state_nxt = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!i_spi_busy) begin
                    w_finish    = 1'b1;
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
`ifdef SPI_ARB_TIMEOUT_EN
        // A normal transition on the same edge wins over the watchdog.
        if (w_to_hit && (w_state_nxt == r_state)) begin
            w_timeout   = 1'b1;
            w_finish    = 1'b1;
            w_state_nxt = StIdle;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_last_grant <= ID_W'(N_REQ - 1);
            r_grant_id   <= '0;
            r_spi_data   <= '0;
            r_ack        <= '0;
            r_done       <= '0;
            r_arb_busy   <= 1'b0;
            r_spi_start  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack       <= '0;
            r_done      <= '0;
            // Registered so the start pulse trails ack by one cycle.
            r_spi_start <= (r_state == StStart);
            if (w_grant) begin
                r_ack[w_winner] <= 1'b1;
                r_grant_id      <= w_winner;
                r_last_grant    <= w_winner;
                r_spi_data      <= w_win_data;
                r_arb_busy      <= 1'b1;
            end
            if (w_finish) begin
                r_done[r_grant_id] <= 1'b1;
                r_arb_busy         <= 1'b0;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_to_cnt <= '0;
            end else if (w_waiting) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    assign o_timeout_err = 1'b0;
`endif

    assign o_ack       = r_ack;
    assign o_done      = r_done;
    assign o_grant_id  = r_grant_id;
    assign o_arb_busy  = r_arb_busy;
    assign o_spi_start = r_spi_start;
    assign o_spi_data  = r_spi_data;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: vector table plus hand-written corner sequences.
// Watchdog checks run only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_req_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned BUSY_LEN = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      ack;
    logic [N-1:0]      done;
    logic [1:0]        grant_id;
    logic              arb_busy;
    logic              spi_start;
    logic [DW-1:0]     spi_data;
    logic              spi_busy;
    logic              timeout_err;

    // Simple spi_master stand-in: busy for BUSY_LEN cycles after accepting start.
    logic              m_busy = 1'b0;
    logic [3:0]        m_cnt = '0;
    logic [DW-1:0]     m_byte = '0;
    int                m_starts = 0;
    logic              m_kill = 1'b0;
    logic              m_stuck = 1'b0;

    int                ack_cnt = 0;
    int                n_cmp = 0;
    int                n_err = 0;

    typedef struct {
        logic [N-1:0]  req;
        logic [N-1:0]  exp_ack;
        logic [1:0]    exp_id;
        logic [DW-1:0] exp_byte;
    } vec_t;

    vec_t vecs[12];

    assign req_data = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
    assign spi_busy = (m_busy & ~m_kill) | m_stuck;

    spi_req_arbiter #(
        .N_REQ       (N),
        .DATA_W      (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_req_data    (req_data),
        .o_ack         (ack),
        .o_done        (done),
        .o_grant_id    (grant_id),
        .o_arb_busy    (arb_busy),
        .o_spi_start   (spi_start),
        .o_spi_data    (spi_data),
        .i_spi_busy    (spi_busy),
        .o_timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
        end else if (!m_busy && spi_start) begin
            m_busy   <= 1'b1;
            m_cnt    <= 4'(BUSY_LEN);
            m_byte   <= spi_data;
            m_starts <= m_starts + 1;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 4'd1;
            if (m_cnt == 4'd1) begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (ack != '0) begin
            ack_cnt <= ack_cnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ack(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (ack != '0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no ack within 40 cycles, expected one", nm);
        end
    endtask

    task automatic wait_done(input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (done != '0) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no done within 40 cycles, expected one", nm);
        end
    endtask

    initial begin
        bit ok;
        int a0;
        int s0;
        int k;

        // Contention from reset, then single, fairness and wrap-around cases.
        vecs[0]  = '{4'b1111, 4'b0001, 2'd0, 8'hA5};
        vecs[1]  = '{4'b1110, 4'b0010, 2'd1, 8'h3C};
        vecs[2]  = '{4'b1100, 4'b0100, 2'd2, 8'h5A};
        vecs[3]  = '{4'b1000, 4'b1000, 2'd3, 8'hC3};
        vecs[4]  = '{4'b0001, 4'b0001, 2'd0, 8'hA5};
        vecs[5]  = '{4'b0101, 4'b0100, 2'd2, 8'h5A};
        vecs[6]  = '{4'b0101, 4'b0001, 2'd0, 8'hA5};
        vecs[7]  = '{4'b0101, 4'b0100, 2'd2, 8'h5A};
        vecs[8]  = '{4'b0101, 4'b0001, 2'd0, 8'hA5};
        vecs[9]  = '{4'b0010, 4'b0010, 2'd1, 8'h3C};
        vecs[10] = '{4'b1001, 4'b1000, 2'd3, 8'hC3};
        vecs[11] = '{4'b1001, 4'b0001, 2'd0, 8'hA5};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_done", done, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_spi_start", spi_start, 0);
        chk("rst_spi_data", spi_data, 0);
        chk("rst_timeout_err", timeout_err, 0);

        for (int v = 0; v < 12; v++) begin
            req = vecs[v].req;
            wait_ack("vec_ack_wait", ok);
            if (ok) begin
                chk("vec_ack", ack, vecs[v].exp_ack);
                chk("vec_grant_id", grant_id, vecs[v].exp_id);
                chk("vec_spi_data", spi_data, vecs[v].exp_byte);
                chk("vec_arb_busy", arb_busy, 1);
                chk("vec_start_early", spi_start, 0);
                req = '0;
                @(negedge clk);
                chk("vec_spi_start", spi_start, 1);
                chk("vec_ack_width", ack, 0);
                wait_done("vec_done_wait", ok);
                if (ok) begin
                    chk("vec_done", done, vecs[v].exp_ack);
                    chk("vec_busy_drop", arb_busy, 0);
                    chk("vec_mosi_byte", m_byte, vecs[v].exp_byte);
                end
            end
            req = '0;
        end

        // Withdraw: req[1] raised while busy and dropped before IDLE.
        req = 4'b0001;
        wait_ack("wd_ack_wait", ok);
        chk("wd_ack", ack, 4'b0001);
        req = 4'b0010;
        repeat (2) @(negedge clk);
        a0 = ack_cnt;
        s0 = m_starts;
        req = '0;
        wait_done("wd_done_wait", ok);
        repeat (4) @(negedge clk);
        chk("wd_no_ack", ack_cnt - a0, 0);
        chk("wd_no_xfer", m_starts - s0, 0);

        // Master busy in IDLE blocks every grant.
        a0 = ack_cnt;
        m_stuck = 1'b1;
        req = 4'b0100;
        repeat (6) @(negedge clk);
        chk("stuck_no_ack", ack_cnt - a0, 0);
        chk("stuck_arb_busy", arb_busy, 0);
        m_stuck = 1'b0;
        wait_ack("stuck_ack_wait", ok);
        chk("stuck_ack", ack, 4'b0100);
        req = '0;
        wait_done("stuck_done_wait", ok);
        chk("stuck_done", done, 4'b0100);

        // Reset during WAIT_LO of requester 1; afterwards 1 must beat 3 again.
        req = 4'b0010;
        wait_ack("rst_ack_wait", ok);
        chk("mid_ack", ack, 4'b0010);
        req = '0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (spi_busy) ok = 1'b1;
        end
        chk("mid_busy_seen", ok, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_grant_id", grant_id, 0);
        chk("mid_rst_arb_busy", arb_busy, 0);
        chk("mid_rst_spi_start", spi_start, 0);
        chk("mid_rst_spi_data", spi_data, 0);
        chk("mid_rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        req = 4'b1010;
        wait_ack("post_rst_ack_wait", ok);
        chk("post_rst_ack", ack, 4'b0010);
        chk("post_rst_grant_id", grant_id, 1);
        req = '0;
        wait_done("post_rst_done_wait", ok);
        chk("post_rst_done", done, 4'b0010);
        chk("post_rst_byte", m_byte, 8'h3C);

`ifdef SPI_ARB_TIMEOUT_EN
        // Busy never seen: done 16 cycles after entering WAIT_HI (17 after ack).
        m_kill = 1'b1;
        req = 4'b0001;
        wait_ack("to_ack_wait", ok);
        chk("to_ack", ack, 4'b0001);
        req = '0;
        ok = 1'b0;
        k = 0;
        while (!ok && k < 40) begin
            @(negedge clk);
            k++;
            if (done != '0) ok = 1'b1;
        end
        chk("to_cycles", k, 17);
        chk("to_done", done, 4'b0001);
        chk("to_err", timeout_err, 1);
        chk("to_arb_busy", arb_busy, 0);
        m_kill = 1'b0;
        repeat (8) @(negedge clk);
        chk("to_err_sticky", timeout_err, 1);
`else
        k = 0;
        chk("err_tied_low", timeout_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
